// File: rtl/modsq_coeff_normalizer.sv
// Carry-propagating return path for the modular squarer: folds redundant
// BIT_LEN-bit coefficients into canonical WORD_LEN digits, one per cycle.
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 32
`endif

module modsq_coeff_normalizer #(
  parameter int MOD_LEN               = `MOD_LEN_DEF,
  parameter int WORD_LEN              = 16,
  parameter int BIT_LEN               = 17,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int CARRY_BITS            = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [SQ_OUT_BITS-1:0]           sq_out,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0] out_data,
  output logic [CARRY_BITS-1:0]            out_carry
);

  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int DW    = NUM_ELEMENTS * WORD_LEN;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                                state_q, state_d;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  coeff_q, coeff_d;
  logic [CARRY_BITS-1:0]                 carry_q, carry_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [DW-1:0]                         data_q, data_d;
  logic [CARRY_BITS-1:0]                 ocarry_q, ocarry_d;
  logic [BIT_LEN:0]                      sum;

  // Padding bits above each coefficient slot carry no information.
  logic unused_sq;
  assign unused_sq = ^sq_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      coeff_q  <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ocarry_q <= '0;
    end else begin
      state_q  <= state_d;
      coeff_q  <= coeff_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ocarry_q <= ocarry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    coeff_d  = coeff_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    data_d   = data_q;
    ocarry_d = ocarry_q;
    sum      = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < NUM_ELEMENTS; j++)
            coeff_d[j] = sq_out[j*2*WORD_LEN +: BIT_LEN];
          carry_d = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sum     = (BIT_LEN+1)'(coeff_q[idx_q]) + (BIT_LEN+1)'(carry_q);
        // Digits enter at the top; after NUM_ELEMENTS shifts digit 0 sits at the bottom.
        data_d  = {sum[WORD_LEN-1:0], data_q[DW-1:WORD_LEN]};
        carry_d = CARRY_BITS'(sum >> WORD_LEN);
        if (idx_q == IDX_W'(NUM_ELEMENTS - 1)) begin
          ocarry_d = carry_d;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_carry = ocarry_q;

endmodule

// File: tb/tb_modsq_coeff_normalizer.sv
// Scoreboard bench: driver pushes the arithmetic value of each accepted
// input; a monitor pops and compares on every output handshake.
module tb_modsq_coeff_normalizer;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BL = 17;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*32-1:0] sq_out = '0;
  logic            in_ready, out_valid;
  logic [N*W-1:0]  out_data;
  logic [1:0]      out_carry;

  always #5 clk = ~clk;

  modsq_coeff_normalizer #(.MOD_LEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sq_out(sq_out),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [65:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Value of a redundant polynomial evaluated at radix 2^16.
  function automatic logic [65:0] model(input logic [N-1:0][BL-1:0] c);
    logic [65:0] v = '0;
    for (int j = 0; j < N; j++) v += 66'(c[j]) << (W * j);
    return v;
  endfunction

  task automatic send(input logic [N-1:0][BL-1:0] c, input bit ones);
    bit ok = 1'b0;
    for (int j = 0; j < N; j++) begin
      sq_out[j*32 +: BL]      = c[j];
      sq_out[j*32 + BL +: 15] = ones ? 15'h7fff : 15'($urandom);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready never high");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(c));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = i; return; end
    end
    n_chk++;
    $display("FAIL valid_timeout: out_valid never rose");
  endtask

  // Monitor: compare on handshake, and check outputs stay frozen while stalled.
  initial begin
    logic [65:0] prev = '0;
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) pv = 1'b0;
      else begin
        if (pv && out_valid) chk("frozen", {out_carry, out_data}, prev);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_out: got %h with nothing expected", {out_carry, out_data});
          end else chk("result", {out_carry, out_data}, exp_q.pop_front());
          pv = 1'b0;
        end else begin
          pv   = out_valid;
          prev = {out_carry, out_data};
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [N-1:0][BL-1:0] c;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    reset = 1'b0;

    // 1: zeros, latency
    out_ready = 1'b1;
    c = '0;
    send(c, 1'b0);
    wait_valid(k);
    chk("t1_latency", k, N);
    chk("t1_value", {out_carry, out_data}, 66'h0);
    @(posedge clk); #1;
    chk("t1_valid_drop", out_valid, 0);

    // 2: all-max coefficients, largest carry
    for (int j = 0; j < N; j++) c[j] = 17'h1ffff;
    send(c, 1'b0);
    wait_valid(k);
    chk("t2_value", {out_carry, out_data}, {2'd2, 64'h0001_0001_0000_ffff});
    @(posedge clk); #1;

    // 3: padding bits ignored
    c = '0; c[1] = 17'h10000;
    send(c, 1'b1);
    wait_valid(k);
    chk("t3_value", {out_carry, out_data}, {2'd0, 64'h0000_0001_0000_0000});
    @(posedge clk); #1;

    // 4: stall in DONE with a competing input
    out_ready = 1'b0;
    for (int j = 0; j < N; j++) c[j] = 17'($urandom);
    send(c, 1'b0);
    wait_valid(k);
    sq_out   = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_valid_held", out_valid, 1);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_data_held", {out_carry, out_data}, model(c));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_released", out_valid, 0);
    chk("t4_idle_no_take", in_ready, 1);
    in_valid = 1'b0;

    // 5: reset mid-accumulation, then a clean result
    for (int j = 0; j < N; j++) c[j] = 17'($urandom);
    send(c, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_data_zero", out_data, 0);
    chk("t5_carry_zero", out_carry, 0);
    chk("t5_valid_zero", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    void'(exp_q.pop_back());
    @(posedge clk); #1 reset = 1'b0;
    for (int j = 0; j < N; j++) c[j] = 17'($urandom);
    send(c, 1'b0);
    wait_valid(k);
    chk("t5_fresh", {out_carry, out_data}, model(c));
    @(posedge clk); #1;

    // 6: random back-to-back traffic with random out_ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < N; j++) c[j] = 17'($urandom);
      send(c, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    rand_rdy = 1'b0;
    #2 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
